step_sequencer: RTL and testbench

Controller that sequences the shared clock divider through a programmable list of notes. It holds a table of STEPS entries, each a divider limit and a duration in beats. On start it loads each entry's limit onto the divider and holds it for the entry's duration, counted in beat ticks from a separate tempo divider. It supports pause, resume, stop and looping, and sits between the register/control interface and the tone divider in the synth datapath.

---
 rtl/seq_pkg.sv | 18 +
 rtl/step_table.sv | 37 +++
 rtl/step_sequencer.sv | 177 +++++++++++++++++
 tb/tb_step_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default widths for the step sequencer.
package seq_pkg;

    localparam int unsigned DEF_BITLEN = 8;
    localparam int unsigned DEF_DURW   = 4;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSED
    } seq_state_t;

    typedef struct packed {
        logic [DEF_BITLEN-1:0] lim;
        logic [DEF_DURW-1:0]   dur;
    } step_t;

endpackage

// File: rtl/step_table.sv
// Step table: register file with synchronous write and clear, two asynchronous read ports.
module step_table #(
    parameter int unsigned STEPS = 8,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(STEPS)-1:0] rd_addr_a,
    output logic [WIDTH-1:0]         rd_data_a,
    input  logic [$clog2(STEPS)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_b
);

    logic [STEPS-1:0][WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_a = mem_q[rd_addr_a];
    assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/step_sequencer.sv
// Plays a programmable list of {divider limit, beat duration} steps onto the tone divider.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned BITLEN = 8,
    parameter int unsigned STEPS  = 8,
    parameter int unsigned DURW   = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [BITLEN-1:0]        wr_lim,
    input  logic [DURW-1:0]          wr_dur,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic                     beat_tick,
    output logic [BITLEN-1:0]        div_lim,
    output logic                     div_en,
    output logic                     div_restart,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IW = $clog2(STEPS);
    localparam int unsigned EW = BITLEN + DURW;

    seq_state_t        state_q, state_d;
    logic [BITLEN-1:0] lim_q, lim_d;
    logic              en_q, en_d;
    logic              restart_q, restart_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DURW-1:0]   rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [EW-1:0]     ent_first, ent_next;
    logic [IW-1:0]     nxt_idx;
    logic              at_last;
    logic              do_load, load_first;
    logic [BITLEN-1:0] ld_lim;
    logic [DURW-1:0]   ld_dur;
    logic [IW-1:0]     ld_idx;

    assign nxt_idx = idx_q + 1'b1;
    assign at_last = (idx_q == IW'(STEPS - 1));

    step_table #(
        .STEPS (STEPS),
        .WIDTH (EW)
    ) u_table (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   ({wr_lim, wr_dur}),
        .rd_addr_a ('0),
        .rd_data_a (ent_first),
        .rd_addr_b (nxt_idx),
        .rd_data_b (ent_next)
    );

    // Load source is either step 0 (start / loop wrap) or the following step.
    always_comb begin
        ld_lim = load_first ? ent_first[EW-1:DURW] : ent_next[EW-1:DURW];
        ld_dur = load_first ? ent_first[DURW-1:0]  : ent_next[DURW-1:0];
        ld_idx = load_first ? '0 : nxt_idx;
    end

    always_comb begin
        state_d    = state_q;
        lim_d      = lim_q;
        en_d       = en_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        restart_d  = 1'b0;
        done_d     = 1'b0;
        do_load    = 1'b0;
        load_first = 1'b0;

        if (stop) begin
            state_d = IDLE;
            lim_d   = '0;
            en_d    = 1'b0;
            idx_d   = '0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (ent_first[DURW-1:0] == '0) begin
                            done_d = 1'b1;
                        end else begin
                            do_load    = 1'b1;
                            load_first = 1'b1;
                            state_d    = PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (pause) begin
                        state_d = PAUSED;
                        en_d    = 1'b0;
                    end else if (beat_tick) begin
                        if (rem_q > DURW'(1)) begin
                            rem_d = rem_q - 1'b1;
                        end else if (at_last || ent_next[DURW-1:0] == '0) begin
                            if (loop_en) begin
                                do_load    = 1'b1;
                                load_first = 1'b1;
                            end else begin
                                state_d = IDLE;
                                lim_d   = '0;
                                en_d    = 1'b0;
                                idx_d   = '0;
                                rem_d   = '0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            do_load = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = PLAY;
                        en_d    = (lim_q != '0);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_load) begin
            lim_d     = ld_lim;
            en_d      = (ld_lim != '0);
            restart_d = 1'b1;
            idx_d     = ld_idx;
            rem_d     = ld_dur;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q   <= IDLE;
            lim_q     <= '0;
            en_q      <= 1'b0;
            restart_q <= 1'b0;
            idx_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lim_q     <= lim_d;
            en_q      <= en_d;
            restart_q <= restart_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign div_lim     = lim_q;
    assign div_en      = en_q;
    assign div_restart = restart_q;
    assign step_idx    = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios plus randomized tables vs a beat-timeline model.
module tb_step_sequencer;

    localparam int BITLEN = 8;
    localparam int STEPS  = 8;
    localparam int DURW   = 4;
    localparam int IW     = $clog2(STEPS);
    localparam int OW     = 4 + IW + BITLEN;

    logic              clk = 1'b0;
    logic              n_rst, wr_en, start, pause, stop, loop_en, beat_tick;
    logic [IW-1:0]     wr_addr;
    logic [BITLEN-1:0] wr_lim;
    logic [DURW-1:0]   wr_dur;
    logic [BITLEN-1:0] div_lim;
    logic              div_en, div_restart, busy, done;
    logic [IW-1:0]     step_idx;

    int tests = 0;
    int fails = 0;
    int m_lim[STEPS];
    int m_dur[STEPS];

    always #5 clk = ~clk;

    step_sequencer #(
        .BITLEN (BITLEN),
        .STEPS  (STEPS),
        .DURW   (DURW)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_lim      (wr_lim),
        .wr_dur      (wr_dur),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .loop_en     (loop_en),
        .beat_tick   (beat_tick),
        .div_lim     (div_lim),
        .div_en      (div_en),
        .div_restart (div_restart),
        .step_idx    (step_idx),
        .busy        (busy),
        .done        (done)
    );

    // Observed output bundle: {busy, done, div_restart, div_en, step_idx, div_lim}.
    wire [OW-1:0] obs = {busy, done, div_restart, div_en, step_idx, div_lim};

    function automatic logic [OW-1:0] pack(input bit b, input bit d, input bit r, input bit e,
                                           input int idx, input int lim);
        logic [IW-1:0]     i_v;
        logic [BITLEN-1:0] l_v;
        i_v = IW'(idx);
        l_v = BITLEN'(lim);
        return {b, d, r, e, i_v, l_v};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        beat_tick = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic prog(input int a, input int l, input int d);
        wr_en   = 1'b1;
        wr_addr = IW'(a);
        wr_lim  = BITLEN'(l);
        wr_dur  = DURW'(d);
        cyc();
        m_lim[a] = l;
        m_dur[a] = d;
    endtask

    task automatic clear_model();
        for (int i = 0; i < STEPS; i++) begin
            m_lim[i] = 0;
            m_dur[i] = 0;
        end
    endtask

    // Beat timeline: steps play in order until a zero duration or the table end.
    function automatic int total_beats();
        int acc = 0;
        for (int i = 0; i < STEPS; i++) begin
            if (m_dur[i] == 0) break;
            acc += m_dur[i];
        end
        return acc;
    endfunction

    function automatic int step_at(input int p);
        int acc = 0;
        for (int i = 0; i < STEPS; i++) begin
            if (m_dur[i] == 0) break;
            acc += m_dur[i];
            if (p < acc) return i;
        end
        return 0;
    endfunction

    function automatic bit is_start(input int p);
        int acc = 0;
        for (int i = 0; i < STEPS; i++) begin
            if (m_dur[i] == 0) break;
            if (p == acc) return 1'b1;
            acc += m_dur[i];
        end
        return 1'b0;
    endfunction

    task automatic run_playback(input int nticks, input string name);
        int total, p, e, gaps;
        logic [OW-1:0] exp_v;
        total = total_beats();
        start = 1'b1;
        cyc();
        exp_v = pack(1, 0, 1, m_lim[0] != 0, 0, m_lim[0]);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s first_load got %h want %h", name, obs, exp_v);
        end
        for (int t = 1; t <= nticks; t++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                cyc();
                tests++;
                if ({done, div_restart} !== 2'b00) begin
                    fails++;
                    $display("FAIL %s gap t=%0d done/restart got %b want 00", name, t,
                             {done, div_restart});
                end
            end
            beat_tick = 1'b1;
            cyc();
            if (!loop_en && t == total) begin
                exp_v = pack(0, 1, 0, 0, 0, 0);
            end else begin
                p = t % total;
                e = step_at(p);
                exp_v = pack(1, 0, is_start(p), m_lim[e] != 0, e, m_lim[e]);
            end
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL %s tick=%0d got %h want %h", name, t, obs, exp_v);
            end
        end
        cyc();
        tests++;
        if ({done, div_restart} !== 2'b00) begin
            fails++;
            $display("FAIL %s pulse_width got %b want 00", name, {done, div_restart});
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        cyc();
        cyc();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_state got %h want 0", obs);
        end
        n_rst = 1'b0;
        clear_model();
        cyc();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL idle_after_reset got %h want 0", obs);
        end
        start = 1'b1;
        cyc();
        tests++;
        if (obs !== pack(0, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL empty_start got %h want %h", obs, pack(0, 1, 0, 0, 0, 0));
        end
        cyc();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL empty_done_width got %h want 0", obs);
        end
    endtask

    task automatic program_example();
        prog(0, 10, 2);
        prog(1, 0, 1);
        prog(2, 20, 3);
        prog(3, 0, 0);
    endtask

    task automatic test_sequence();
        program_example();
        loop_en = 1'b0;
        run_playback(6, "seq");
    endtask

    task automatic test_loop();
        loop_en = 1'b1;
        run_playback(9, "loop");
        stop = 1'b1;
        cyc();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL loop_stop got %h want 0", obs);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_pause_resume();
        logic [OW-1:0] exp_v;
        start = 1'b1;
        cyc();
        repeat (4) begin
            beat_tick = 1'b1;
            cyc();
        end
        pause = 1'b1;
        cyc();
        exp_v = pack(1, 0, 0, 0, 2, 20);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL paused got %h want %h", obs, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            beat_tick = 1'b1;
            pause     = (i == 2);
            cyc();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL paused_tick%0d got %h want %h", i, obs, exp_v);
            end
        end
        start = 1'b1;
        cyc();
        exp_v = pack(1, 0, 0, 1, 2, 20);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL resume got %h want %h", obs, exp_v);
        end
        beat_tick = 1'b1;
        cyc();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL resume_tick1 got %h want %h", obs, exp_v);
        end
        beat_tick = 1'b1;
        cyc();
        tests++;
        if (obs !== pack(0, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL resume_end got %h want %h", obs, pack(0, 1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_simultaneous();
        start = 1'b1;
        cyc();
        stop  = 1'b1;
        start = 1'b1;
        cyc();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL stop_start got %h want 0", obs);
        end
        start     = 1'b1;
        beat_tick = 1'b1;
        cyc();
        tests++;
        if (obs !== pack(1, 0, 1, 1, 0, 10)) begin
            fails++;
            $display("FAIL start_tick got %h want %h", obs, pack(1, 0, 1, 1, 0, 10));
        end
        beat_tick = 1'b1;
        cyc();
        tests++;
        if (obs !== pack(1, 0, 0, 1, 0, 10)) begin
            fails++;
            $display("FAIL first_tick got %h want %h", obs, pack(1, 0, 0, 1, 0, 10));
        end
        pause     = 1'b1;
        beat_tick = 1'b1;
        cyc();
        tests++;
        if (obs !== pack(1, 0, 0, 0, 0, 10)) begin
            fails++;
            $display("FAIL pause_tick got %h want %h", obs, pack(1, 0, 0, 0, 0, 10));
        end
        start = 1'b1;
        cyc();
        beat_tick = 1'b1;
        cyc();
        tests++;
        if (obs !== pack(1, 0, 1, 0, 1, 0)) begin
            fails++;
            $display("FAIL after_pause_tick got %h want %h", obs, pack(1, 0, 1, 0, 1, 0));
        end
        stop = 1'b1;
        cyc();
        pause = 1'b1;
        cyc();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL idle_pause got %h want 0", obs);
        end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < STEPS; i++) begin
            prog(i, $urandom_range(1, 255), $urandom_range(1, 3));
        end
        loop_en = 1'b0;
        run_playback(total_beats(), "full");
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < STEPS; i++) begin
                prog(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                     (i != 0 && $urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3));
            end
            loop_en = 1'($urandom_range(0, 1));
            n = total_beats();
            if (loop_en) n += $urandom_range(1, n);
            run_playback(n, $sformatf("rand%0d", k));
            stop = 1'b1;
            cyc();
            loop_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        prog(0, 55, 2);
        start = 1'b1;
        cyc();
        beat_tick = 1'b1;
        cyc();
        n_rst = 1'b1;
        cyc();
        n_rst = 1'b0;
        clear_model();
        tests++;
        if (obs !== '0) begin
            fails++;
            $display("FAIL reset_mid got %h want 0", obs);
        end
        start = 1'b1;
        cyc();
        tests++;
        if (obs !== pack(0, 1, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL reset_cleared_table got %h want %h", obs, pack(0, 1, 0, 0, 0, 0));
        end
    endtask

    initial begin
        n_rst     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_lim    = '0;
        wr_dur    = '0;
        start     = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        loop_en   = 1'b0;
        beat_tick = 1'b0;
        test_reset();
        test_sequence();
        test_loop();
        test_pause_resume();
        test_simultaneous();
        test_full_table();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
